alu_serial_seq: RTL and testbench

- Bit-serial sequencer that computes a WIDTH-bit MIPS ALU operation by stepping one internal alu_1bit slice across the operand bits, LSB first.
- Latches the operands and op, drives the slice one bit per cycle, and chains the carry through a register.
- Handles the SLT fix-up and overflow detection, then presents the full-width result with a done pulse.
- Sits between the control unit and the register file, as a low-area execute unit.

---
 rtl/alu_serial_seq.sv | 102 ++++++++++
 tb/tb_alu_serial_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial MIPS ALU sequencer stepping a 1-bit slice LSB first
module alu_serial_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_r, b_r;
    logic [2:0]       op_r;
    logic [CNT_W-1:0] cnt;
    logic             carry, c_in_msb, sum_msb;
    logic             legal, last, bi, s, co;
    logic [1:0]       sop;
    always_comb begin
        legal = (op[1:0] == 2'b10) || (op == 3'b000) || (op == 3'b001) || (op == 3'b111);
        last  = cnt == CNT_W'(WIDTH - 1);
        bi    = b_r[0] ^ op_r[2];
        co    = (a_r[0] & bi) | (a_r[0] & carry) | (bi & carry);
        sop   = (op_r == 3'b111) ? 2'b10 : op_r[1:0];
        s     = (sop == 2'b00) ? a_r[0] & bi :
                (sop == 2'b01) ? a_r[0] | bi :
                (sop == 2'b10) ? a_r[0] ^ bi ^ carry : 1'b0;
    end
    // operands shift right so the slice always sees bit 0; result fills from the MSB end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            c_in_msb <= 1'b0;
            sum_msb  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_r      <= a;
                    b_r      <= b;
                    op_r     <= op;
                    cnt      <= '0;
                    carry    <= op[2];
                    result   <= '0;
                    cout     <= 1'b0;
                    overflow <= 1'b0;
                    zero     <= 1'b0;
                    err      <= ~legal;
                    busy     <= legal;
                    state    <= legal ? RUN : DONE;
                end
                RUN: begin
                    a_r    <= a_r >> 1;
                    b_r    <= b_r >> 1;
                    result <= {s, result[WIDTH-1:1]};
                    carry  <= co;
                    cnt    <= last ? cnt : cnt + 1'b1;
                    if (last) begin
                        c_in_msb <= carry;
                        sum_msb  <= s;
                        busy     <= op_r == 3'b111;
                        state    <= (op_r == 3'b111) ? FIXUP : DONE;
                    end
                end
                FIXUP: begin
                    result <= {{(WIDTH-1){1'b0}}, sum_msb ^ c_in_msb ^ carry};
                    busy   <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    done     <= 1'b1;
                    cout     <= op_r[1] & ~err & carry;
                    overflow <= op_r[1] & ~op_r[0] & ~err & (c_in_msb ^ carry);
                    zero     <= ~|result;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: directed checks of the serial ALU sequencer at WIDTH=8
module tb_alu_serial_seq;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, cout, overflow, zero, err;
    logic [7:0] result;
    int vectors = 0, miscompares = 0;

    alu_serial_seq #(.WIDTH(8), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout),
        .overflow(overflow), .zero(zero), .err(err)
    );

    always #5 clk = ~clk;

    task automatic launch(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, output int lat);
        launch(o, x, y);
        wait_done(lat);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, result, cout, overflow, zero, err} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b result=%h cout=%b ovf=%b zero=%b err=%b, need 0 0 00 0 0 1 0",
                     busy, done, result, cout, overflow, zero, err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        int lat;
        launch(3'b010, 8'hFF, 8'h01);
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL add_busy: busy=%b, need 1", busy);
        end
        wait_done(lat);
        lat = lat + 1;
        vectors++;
        if (lat !== 9) begin
            miscompares++;
            $display("FAIL add_latency: got %0d, need 9", lat);
        end
        vectors++;
        if ({result, cout, zero, overflow, busy} !== {8'h00, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL add_ff_01: result=%h cout=%b zero=%b ovf=%b busy=%b, need 00 1 1 0 0",
                     result, cout, zero, overflow, busy);
        end
    endtask

    task automatic test_sub;
        int lat;
        run_op(3'b110, 8'h80, 8'h01, lat);
        vectors++;
        if ({lat[4:0], result, cout, overflow, zero} !== {5'd9, 8'h7F, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_80_01: lat=%0d result=%h cout=%b ovf=%b zero=%b, need 9 7f 1 1 0",
                     lat, result, cout, overflow, zero);
        end
        run_op(3'b110, 8'h05, 8'h05, lat);
        vectors++;
        if ({result, cout, overflow, zero} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL sub_05_05: result=%h cout=%b ovf=%b zero=%b, need 00 1 0 1",
                     result, cout, overflow, zero);
        end
    endtask

    task automatic test_slt;
        int lat;
        logic [7:0] va [3] = '{8'hFE, 8'h05, 8'h80};
        logic [7:0] vb [3] = '{8'h01, 8'h03, 8'h7F};
        logic [7:0] ve [3] = '{8'h01, 8'h00, 8'h01};
        for (int i = 0; i < 3; i++) begin
            run_op(3'b111, va[i], vb[i], lat);
            vectors++;
            if (lat !== 10 || result !== ve[i] || overflow !== 1'b0) begin
                miscompares++;
                $display("FAIL slt_%0d: lat=%0d result=%h ovf=%b, need 10 %h 0", i, lat, result, overflow, ve[i]);
            end
        end
    endtask

    task automatic test_logic;
        int lat;
        run_op(3'b000, 8'hA5, 8'h3C, lat);
        vectors++;
        if ({lat[4:0], result, cout, overflow, zero} !== {5'd9, 8'h24, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL and: lat=%0d result=%h cout=%b ovf=%b zero=%b, need 9 24 0 0 0",
                     lat, result, cout, overflow, zero);
        end
        run_op(3'b001, 8'hA5, 8'h3C, lat);
        vectors++;
        if ({lat[4:0], result, cout, overflow} !== {5'd9, 8'hBD, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL or: lat=%0d result=%h cout=%b ovf=%b, need 9 bd 0 0", lat, result, cout, overflow);
        end
    endtask

    task automatic test_back_to_back;
        int lat, pulses;
        launch(3'b010, 8'h10, 8'h20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; op = 3'b110; a = 8'h77; b = 8'h11;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        lat = lat + 3;
        vectors++;
        if (lat !== 9 || result !== 8'h30) begin
            miscompares++;
            $display("FAIL ignore_start: lat=%0d result=%h, need 9 30", lat, result);
        end
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        vectors++;
        if (pulses !== 0 || result !== 8'h30) begin
            miscompares++;
            $display("FAIL single_done: extra pulses=%0d result=%h, need 0 30", pulses, result);
        end
        launch(3'b010, 8'h01, 8'h02);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({busy, done, result, cout, overflow, zero, err} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: busy=%b done=%b result=%h cout=%b ovf=%b zero=%b err=%b, need 0 0 00 0 0 1 0",
                     busy, done, result, cout, overflow, zero, err);
        end
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: active cycles=%0d, need 0", pulses);
        end
    endtask

    task automatic test_illegal;
        int lat;
        run_op(3'b011, 8'h12, 8'h34, lat);
        vectors++;
        if ({lat[4:0], err, result, zero, cout, overflow} !== {5'd1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL illegal_op: lat=%0d err=%b result=%h zero=%b cout=%b ovf=%b, need 1 1 00 1 0 0",
                     lat, err, result, zero, cout, overflow);
        end
        run_op(3'b010, 8'h03, 8'h04, lat);
        vectors++;
        if ({lat[4:0], err, result, cout} !== {5'd9, 1'b0, 8'h07, 1'b0}) begin
            miscompares++;
            $display("FAIL err_clear: lat=%0d err=%b result=%h cout=%b, need 9 0 07 0", lat, err, result, cout);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_back_to_back();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
